uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Receive-side UART frame sequencer. Synchronises the serial line, detects the start
//   edge and drives a baud timer to sample mid-bit. Assembles LSB-first data and checks
//   the stop bit. Delivers each byte over a valid/ready handshake to the downstream consumer.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per serial bit (>=4); 50 MHz / 115200 baud
//   DATA_BITS     8    data bits per frame (5..9)
// PORTS
//   clk           in   1          system clock, all logic on rising edge
//   rst_n         in   1          asynchronous, active-low reset
//   rx_i          in   1          raw serial line, idle high, asynchronous to clk
//   data_o        out  DATA_BITS  received byte, stable while valid_o=1
//   valid_o       out  1          byte available; held until ready_i=1
//   ready_i       in   1          consumer accepts data_o when valid_o&&ready_i
//   busy_o        out  1          1 in any state other than IDLE
//   frame_err_o   out  1          1-cycle pulse: stop bit sampled low
//   overrun_o     out  1          1-cycle pulse: byte completed while previous unaccepted
//   parity_err_o  out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//   - Reset: all outputs 0, data_o=0, state IDLE, synchroniser flops preset to 1.
//   - rx_i passes a 2-flop synchroniser; all decisions use the synchronised rxs.
//   - Timer: down-counter, width $clog2(CLKS_PER_BIT); tick when count==0 and armed.
//     HALF load = CLKS_PER_BIT/2-1, FULL load = CLKS_PER_BIT-1; it reloads FULL on every tick.
//   - IDLE: rxs falling edge -> load HALF, go to START.
//   - START: on tick, rxs=0 -> DATA, bit_cnt=0. rxs=1 (glitch) -> IDLE, no flag raised.
//   - DATA: on tick, shift rxs into shreg MSB, shifting right (LSB-first).
//     After DATA_BITS samples -> STOP (PARITY when macro set).
//   - STOP: on tick, rxs=1 -> deliver byte, then IDLE.
//     rxs=0 -> frame_err_o pulse, byte dropped, go to BREAK.
//   - BREAK: wait for rxs=1, then IDLE. A held-low line never starts a new frame.
//   - Deliver: valid_o/data_o register 1 cycle after the stop-sample tick.
//   - Handshake:
//     - valid_o falls the cycle after valid_o&&ready_i.
//     - New byte with valid_o=0, or with valid_o&&ready_i in the same cycle: load, valid_o=1.
//     - New byte with valid_o=1 and ready_i=0: overrun_o pulse; new byte discarded, old data_o kept.
//   - Reset mid-frame: immediate return to IDLE; partial byte discarded.
//   - Error pulses are 1 cycle each; frame_err and overrun never assert together.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Extra PARITY state after DATA; one tick samples the even-parity bit.
//     - Mismatch: parity_err_o pulse, byte dropped, STOP still checked (framing precedence).
//   Undefined: no PARITY state; parity_err_o constant 0; frame = start+DATA_BITS+stop.
// STRUCTURE
//   - uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK),
//     timer width function, HALF/FULL load constants.
//   - Sub-module uart_baud_timer: load_half, load_full and arm inputs; tick output.
//     Instantiated once; the FSM, shift register and handshake live in uart_rx_ctrl.
// TESTING  (CLKS_PER_BIT=16, DATA_BITS=8 unless noted)
//   1. Frame 0xA5 8N1, ready_i=1 -> data sampled at edge+2+8+16k cycles.
//      valid_o high 1 cycle, data_o=0xA5; no error pulses.
//   2. rx_i low for 4 cycles then high -> START aborts.
//      busy_o drops, valid_o stays 0, no error pulses.
//   3. 0x3C with stop bit 0, line held low 40 cycles -> frame_err_o one pulse, valid_o 0.
//      No new frame until rx_i returns high; next 0x3C received correctly.
//   4. Back-to-back 0x11, 0x22 with ready_i=0 -> valid_o=1 with data_o=0x11.
//      overrun_o one pulse at 0x22 completion; data_o remains 0x11.
//   5. rst_n low for 3 cycles mid-DATA of 0x77 -> all outputs 0 immediately, no valid.
//      Next frame 0x5A received correctly.
//   6. UART_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_err_o pulse, valid_o 0.
//      Then 0x01 with parity bit 1 -> data_o=0x01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding and
// baud-timer sizing helpers.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  // Half load puts the first sample in the middle of the start bit.
  function automatic int half_load(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

  function automatic int full_load(input int clks_per_bit);
    return clks_per_bit - 1;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Down-counting baud timer: ticks when armed and the count reaches zero, then
// reloads the full bit period on every tick.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half_i,
  input  logic load_full_i,
  input  logic arm_i,
  output logic tick_o
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(half_load(CLKS_PER_BIT));
  localparam logic [TW-1:0] FULL = TW'(full_load(CLKS_PER_BIT));

  logic [TW-1:0] cnt_q;
  logic          armed_q;

  assign tick_o = armed_q && arm_i && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_half_i) begin
      cnt_q   <= HALF;
      armed_q <= 1'b1;
    end else if (load_full_i) begin
      cnt_q   <= FULL;
      armed_q <= 1'b1;
    end else if (!arm_i) begin
      armed_q <= 1'b0;
    end else if (tick_o) begin
      cnt_q <= FULL;
    end else if (armed_q) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer with valid/ready output handshake.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o
);

  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync2_q, rxs_prev_q;
  logic                 rxs, rx_fall;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_err_q, overrun_q;
  logic                 tick, load_half, load_full, arm;
  logic                 deliver, stop_bad, par_bad;

  // Synchroniser and edge detector preset to idle-high so reset is not a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
    end
  end

  assign rxs     = sync2_q;
  assign rx_fall = rxs_prev_q && !rxs;

  assign load_half = (state_q == ST_IDLE) && rx_fall;
  assign load_full = (state_q == ST_START) && tick && !rxs;
  assign arm       = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_half_i(load_half),
    .load_full_i(load_full),
    .arm_i      (arm),
    .tick_o     (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE:  if (rx_fall) state_d = ST_START;
      ST_START: if (tick) begin
        state_d   = rxs ? ST_IDLE : ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA:  if (tick) begin
        shreg_d   = {rxs, shreg_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, parity_err_q, par_mismatch;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_mismatch = (state_q == ST_PARITY) && tick && ((^shreg_q) ^ rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= par_mismatch;
      if (load_half)         par_bad_q <= 1'b0;
      else if (par_mismatch) par_bad_q <= 1'b1;
    end
  end

  assign par_bad      = par_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign stop_bad = (state_q == ST_STOP) && tick && !rxs;
  assign deliver  = (state_q == ST_STOP) && tick && rxs && !par_bad;

  // A completed byte is only discarded when the previous one is still unaccepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (deliver) begin
        if (!valid_q || ready_i) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl at CLKS_PER_BIT=16, DATA_BITS=8.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_i;
  logic          ready_i;
  logic [DB-1:0] data_o;
  logic          valid_o, busy_o, frame_err_o, overrun_o, parity_err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [15:0] sb[$];

`ifdef UART_RX_PARITY_EN
  logic par_flip_g = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: count error pulses and pop the scoreboard on every accepted byte.
  always @(negedge clk) begin
    logic [15:0] exp_byte;
    if (rst_n) begin
      if (frame_err_o)  fe_cnt++;
      if (overrun_o)    ov_cnt++;
      if (parity_err_o) pe_cnt++;
      if (valid_o && ready_i) begin
        exp_byte = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        check("rx_data", {24'd0, data_o}, {16'd0, exp_byte});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip_g);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, sb.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_perr", parity_err_o, 0);
    rst_n = 1'b1;
    idle(20);

    // 1: clean 0xA5 frame, consumer ready
    sb.push_back(16'hA5);
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    wait_drain("t1_drain", 100);
    check("t1_busy", busy_o, 0);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);

    // 2: start glitch of 4 cycles
    rx_i = 1'b0;
    idle(4);
    rx_i = 1'b1;
    idle(3);
    check("t2_busy_start", busy_o, 1);
    idle(20);
    check("t2_busy_abort", busy_o, 0);
    check("t2_valid", valid_o, 0);
    check("t2_fe", fe_cnt, 0);
    check("t2_ov", ov_cnt, 0);

    // 3: framing error with line held low, then recovery
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("t3_fe", fe_cnt, 1);
    check("t3_break_busy", busy_o, 1);
    check("t3_valid", valid_o, 0);
    rx_i = 1'b1;
    idle(2 * CPB);
    check("t3_idle", busy_o, 0);
    sb.push_back(16'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    wait_drain("t3_drain", 100);
    check("t3_fe_once", fe_cnt, 1);

    // 4: back-to-back bytes with consumer stalled
    ready_i = 1'b0;
    sb.push_back(16'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("t4_valid", valid_o, 1);
    check("t4_data", data_o, 8'h11);
    check("t4_ov", ov_cnt, 1);
    check("t4_fe", fe_cnt, 1);
    ready_i = 1'b1;
    wait_drain("t4_drain", 20);
    idle(2);
    check("t4_valid_fall", valid_o, 0);

    // 5: reset in the middle of the data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy_o, 0);
    check("t5_valid", valid_o, 0);
    check("t5_data", data_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rx_i  = 1'b1;
    rst_n = 1'b1;
    idle(2 * CPB);
    check("t5_no_valid", valid_o, 0);
    sb.push_back(16'h5A);
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    wait_drain("t5_drain", 100);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch drops the byte, correct parity delivers it
    par_flip_g = 1'b1;
    send_frame(8'h01, 1'b1);
    idle(2 * CPB);
    check("t6_pe", pe_cnt, 1);
    check("t6_valid", valid_o, 0);
    par_flip_g = 1'b0;
    sb.push_back(16'h01);
    send_frame(8'h01, 1'b1);
    idle(2 * CPB);
    wait_drain("t6_drain", 100);
    check("t6_pe_once", pe_cnt, 1);
`else
    check("no_parity_pulses", pe_cnt, 0);
`endif

    check("final_fe", fe_cnt, 1);
    check("final_ov", ov_cnt, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
